key_frame_proc: RTL and testbench
=================================

Name: key_frame_proc

Overview:
- Stage directly downstream of the input-key decoder. Consumes its Active/Mode outputs and feeds Busy back to it.
- Once Active, collects serial data frames of DATA_WIDTH bits. Optionally XORs each frame with a fixed key (Mode=1) or passes it through unchanged (Mode=0).
- Re-serialises the result MSB-first with a valid strobe.
- Asserts Busy for the whole frame so the decoder holds Mode stable.

Parameters:
- DATA_WIDTH, 8: bits per frame, legal range 2..32.
- KEY, 8'hA5: XOR key applied when the latched mode is 1; width DATA_WIDTH.

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- Active  input  1  decoder has accepted the key; enables this block.
- Mode  input  1  0 = pass-through, 1 = XOR with KEY; sampled with the first data bit.
- InputData  input  1  serial data bit, MSB first.
- ValidData  input  1  InputData qualifier; a bit is accepted only on a cycle with ValidData=1 in LOAD.
- Busy  output  1  frame in progress; fed back to the decoder.
- DataOut  output  1  serial result bit, MSB first.
- ValidOut  output  1  DataOut qualifier.
- Done  output  1  one-cycle pulse after the last output bit of a frame.

Behaviour:
- Reset values: Busy=0, DataOut=0, ValidOut=0, Done=0, state=IDLE, bit counter=0, shift register=0, latched mode=0.
- All outputs are registered.
- States: IDLE, LOAD, PROC, SEND, DONE.
- IDLE:
  - Outputs low.
  - Active=1 -> LOAD on the next edge. Otherwise stay in IDLE.
  - ValidData is ignored.
- LOAD:
  - Each cycle with ValidData=1, shift InputData into the LSB of the shift register (MSB arrives first) and increment the counter.
  - Cycles with ValidData=0 are gaps: no shift, counter holds, no timeout.
  - On the first accepted bit (counter=0), latch Mode and set Busy=1 on the same edge.
  - When the bit accepted makes counter = DATA_WIDTH: go to PROC and reset the counter to 0.
- PROC (exactly 1 cycle):
  - Shift register <= register XOR KEY if latched mode=1, else unchanged.
  - Go to SEND.
- SEND (exactly DATA_WIDTH cycles):
  - Each cycle: ValidOut=1, DataOut = current MSB; shift left one bit.
  - InputData/ValidData are ignored.
  - After the last bit, go to DONE.
- DONE (1 cycle):
  - Done=1, ValidOut=0, Busy=0.
  - Next state: LOAD if Active=1, else IDLE.
- Latency: the first ValidOut is registered 2 edges after the edge that samples the last input bit, so there is one dead cycle between them.
  - Busy stays high from the first accepted bit through the last SEND cycle.
- Active falls while in LOAD/PROC/SEND:
  - Abort to IDLE on the next edge.
  - Busy, ValidOut and counter go to 0; no Done pulse.
  - The partial frame is discarded.
- Mode changes mid-frame have no effect; only the value latched with the first bit is used.
- Reset asserted mid-frame: immediate return to reset values with no further output bits. After Reset deasserts, the block restarts in IDLE.
- Back-to-back frames: a ValidData bit presented in the DONE cycle is ignored. Capture resumes in LOAD on the following cycle.

Optional Feature:
- Macro: KEY_FRAME_PARITY_EN.
- Defined:
  - SEND lasts DATA_WIDTH+1 cycles.
  - The extra final bit is the even parity (XOR reduction) of the transmitted, post-XOR word.
  - ValidOut=1 for that bit; Done follows it.
- Undefined: SEND lasts DATA_WIDTH cycles and no parity logic is synthesised.

Test Plan:
- Reset, then Active=1, Mode=0; feed 0x3C MSB-first with ValidData=1 continuously -> Busy rises with bit 0, serial output 0x3C on 8 ValidOut cycles starting 2 cycles after the last input bit, then Done=1 for one cycle with Busy=0.
- Active=1, Mode=1; feed 0x3C -> output 0x99 (0x3C^0xA5); toggle Mode to 0 mid-frame -> output still 0x99.
- Mode=0; feed 0xF0 with ValidData low every other cycle -> output 0xF0; counter holds during the gaps; no early PROC.
- Feed 4 bits of a frame, drop Active -> next edge IDLE, Busy=0, no ValidOut, no Done; re-raise Active and feed 0x81 -> output 0x81 (no stale bits).
- Assert Reset during the 3rd SEND bit of a 0xFF frame -> DataOut/ValidOut/Busy=0 immediately; no further output bits.
- KEY_FRAME_PARITY_EN defined, Mode=1, input 0x3C -> 9 ValidOut bits: 1001_1001 then parity 0. With input 0x38 (result 0x9D) -> parity bit 1.

Source files
------------

// File: rtl/key_frame_proc_if.sv
// Handshake bundle between the input-key decoder (master) and key_frame_proc (slave).
interface key_frame_proc_if;
  logic Active;
  logic Mode;
  logic InputData;
  logic ValidData;
  logic Busy;
  logic DataOut;
  logic ValidOut;
  logic Done;

  modport master (
    output Active, Mode, InputData, ValidData,
    input  Busy, DataOut, ValidOut, Done
  );

  modport slave (
    input  Active, Mode, InputData, ValidData,
    output Busy, DataOut, ValidOut, Done
  );
endinterface

// File: rtl/key_frame_proc.sv
// Collects a serial frame, optionally XORs it with KEY, re-serialises it MSB-first.
// Defining KEY_FRAME_PARITY_EN appends an even-parity bit after the data bits.
module key_frame_proc #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] KEY        = DATA_WIDTH'(8'hA5)
) (
  input logic             Clk,
  input logic             Reset,
  key_frame_proc_if.slave kf
);

`ifdef KEY_FRAME_PARITY_EN
  localparam int unsigned SEND_LEN = DATA_WIDTH + 1;
`else
  localparam int unsigned SEND_LEN = DATA_WIDTH;
`endif
  localparam int unsigned   CW        = $clog2(DATA_WIDTH + 2);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] SEND_LAST = CW'(SEND_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PROC = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [CW-1:0]         cnt_r, cnt_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic                  mode_r, mode_s;
  logic                  busy_r, busy_s;
  logic                  data_r, data_s;
  logic                  valid_r, valid_s;
  logic                  done_r, done_s;
  logic                  abort_s;

`ifdef KEY_FRAME_PARITY_EN
  logic parity_r, parity_s;

  function automatic logic even_parity_f(input logic [DATA_WIDTH-1:0] word);
    even_parity_f = ^word;
  endfunction
`endif

  // Next-state and next-output decode; outputs are registered one cycle behind the state.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    shift_s = shift_r;
    mode_s  = mode_r;
    busy_s  = busy_r;
    data_s  = 1'b0;
    valid_s = 1'b0;
    done_s  = 1'b0;
`ifdef KEY_FRAME_PARITY_EN
    parity_s = parity_r;
`endif
    abort_s = ((state_r == LOAD) || (state_r == PROC) || (state_r == SEND)) && !kf.Active;

    if (abort_s) begin
      state_s = IDLE;
      cnt_s   = CNT_ZERO;
      shift_s = WORD_ZERO;
      busy_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_s   = CNT_ZERO;
          shift_s = WORD_ZERO;
          busy_s  = 1'b0;
          if (kf.Active) begin
            state_s = LOAD;
          end else begin
            state_s = IDLE;
          end
        end
        LOAD: begin
          if (kf.ValidData) begin
            shift_s = {shift_r[DATA_WIDTH-2:0], kf.InputData};
            // Mode is frozen with the first bit so the decoder may change it freely afterwards.
            if (cnt_r == CNT_ZERO) begin
              mode_s = kf.Mode;
              busy_s = 1'b1;
            end else begin
              mode_s = mode_r;
            end
            if (cnt_r == LOAD_LAST) begin
              state_s = PROC;
              cnt_s   = CNT_ZERO;
            end else begin
              cnt_s = cnt_r + CNT_ONE;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        PROC: begin
          if (mode_r) begin
            shift_s = shift_r ^ KEY;
          end else begin
            shift_s = shift_r;
          end
`ifdef KEY_FRAME_PARITY_EN
          parity_s = even_parity_f(shift_s);
`endif
          state_s = SEND;
        end
        SEND: begin
          valid_s = 1'b1;
          shift_s = {shift_r[DATA_WIDTH-2:0], 1'b0};
`ifdef KEY_FRAME_PARITY_EN
          if (cnt_r == SEND_LAST) begin
            data_s = parity_r;
          end else begin
            data_s = shift_r[DATA_WIDTH-1];
          end
`else
          data_s = shift_r[DATA_WIDTH-1];
`endif
          if (cnt_r == SEND_LAST) begin
            state_s = DONE;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          cnt_s   = CNT_ZERO;
          shift_s = WORD_ZERO;
          if (kf.Active) begin
            state_s = LOAD;
          end else begin
            state_s = IDLE;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          shift_s = WORD_ZERO;
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      shift_r  <= WORD_ZERO;
      mode_r   <= 1'b0;
      busy_r   <= 1'b0;
      data_r   <= 1'b0;
      valid_r  <= 1'b0;
      done_r   <= 1'b0;
`ifdef KEY_FRAME_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      shift_r  <= shift_s;
      mode_r   <= mode_s;
      busy_r   <= busy_s;
      data_r   <= data_s;
      valid_r  <= valid_s;
      done_r   <= done_s;
`ifdef KEY_FRAME_PARITY_EN
      parity_r <= parity_s;
`endif
    end
  end

  assign kf.Busy     = busy_r;
  assign kf.DataOut  = data_r;
  assign kf.ValidOut = valid_r;
  assign kf.Done     = done_r;

endmodule

// File: tb/tb_key_frame_proc.sv
// Self-checking bench for key_frame_proc: directed table, abort/reset sequences, random frames.
module tb_key_frame_proc;
  localparam int W = 8;
  localparam logic [W-1:0] KEY = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  key_frame_proc_if kf();

  key_frame_proc #(.DATA_WIDTH(W), .KEY(KEY)) dut (
    .Clk   (clk),
    .Reset (rst),
    .kf    (kf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] word;
    logic         mode;
    int           gaps;
    bit           toggle;
    logic [W-1:0] exp_word;
    logic         exp_par;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: the transmitted word is the frame, XORed with KEY when mode was 1 at the first bit.
  function automatic logic [W-1:0] model_word(input logic [W-1:0] w, input logic m);
    return m ? (w ^ KEY) : w;
  endfunction

  task automatic run_frame(input string tag, input logic [W-1:0] word, input logic mode,
                           input int gaps, input bit toggle,
                           input logic [W-1:0] exp_word, input logic exp_par);
    logic [W-1:0] got;
    logic         par_got;
    bit           quiet;
    bit           busy_ok;
    bit           stream_ok;
    got = '0; par_got = 1'b0; quiet = 1'b1; busy_ok = 1'b1; stream_ok = 1'b1;
    check($sformatf("%s_busy_before", tag), kf.Busy, 32'd0);
    for (int i = W - 1; i >= 0; i--) begin
      if (i != W - 1) begin
        for (int g = 0; g < gaps; g++) begin
          kf.ValidData = 1'b0;
          kf.InputData = 1'($urandom_range(0, 1));
          tick();
          if (kf.ValidOut !== 1'b0) quiet = 1'b0;
          if (kf.Busy !== 1'b1) busy_ok = 1'b0;
        end
      end
      kf.ValidData = 1'b1;
      kf.InputData = word[i];
      kf.Mode      = (toggle && i != W - 1) ? ~mode : mode;
      tick();
      if (i == W - 1) check($sformatf("%s_busy_rise", tag), kf.Busy, 32'd1);
      if (kf.ValidOut !== 1'b0) quiet = 1'b0;
      if (kf.Busy !== 1'b1) busy_ok = 1'b0;
    end
    kf.ValidData = 1'b0;
    check($sformatf("%s_no_early_out", tag), quiet, 32'd1);
    tick();
    check($sformatf("%s_dead_cycle", tag), kf.ValidOut, 32'd0);
    for (int k = 0; k < W; k++) begin
      tick();
      if (kf.ValidOut !== 1'b1) stream_ok = 1'b0;
      if (kf.Busy !== 1'b1) busy_ok = 1'b0;
      got = {got[W-2:0], kf.DataOut};
    end
`ifdef KEY_FRAME_PARITY_EN
    tick();
    if (kf.ValidOut !== 1'b1) stream_ok = 1'b0;
    if (kf.Busy !== 1'b1) busy_ok = 1'b0;
    par_got = kf.DataOut;
    check($sformatf("%s_parity", tag), par_got, {31'd0, exp_par});
`endif
    check($sformatf("%s_word", tag), got, {24'd0, exp_word});
    check($sformatf("%s_valid_run", tag), stream_ok, 32'd1);
    check($sformatf("%s_busy_held", tag), busy_ok, 32'd1);
    // A bit offered during the DONE cycle must be ignored; the next frame proves it.
    kf.ValidData = 1'b1;
    kf.InputData = 1'b1;
    tick();
    check($sformatf("%s_done_busy_valid", tag), {kf.Done, kf.Busy, kf.ValidOut}, 32'b100);
    kf.ValidData = 1'b0;
    tick();
    check($sformatf("%s_done_fall", tag), kf.Done, 32'd0);
  endtask

  initial begin
    bit quiet;
    kf.Active = 1'b0; kf.Mode = 1'b0; kf.InputData = 1'b0; kf.ValidData = 1'b0;
    rst = 1'b1;
    tick(); tick();
    check("reset_outputs", {kf.Busy, kf.DataOut, kf.ValidOut, kf.Done}, 32'd0);
    rst = 1'b0;
    kf.ValidData = 1'b1; kf.InputData = 1'b1;
    tick(); tick();
    check("idle_ignores_valid", {kf.Busy, kf.DataOut, kf.ValidOut, kf.Done}, 32'd0);
    kf.ValidData = 1'b0;
    kf.Active = 1'b1;
    tick();

    vecs[0] = '{8'h3C, 1'b0, 0, 1'b0, 8'h3C, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 0, 1'b1, 8'h99, 1'b0};
    vecs[2] = '{8'hF0, 1'b0, 1, 1'b0, 8'hF0, 1'b0};
    vecs[3] = '{8'h38, 1'b1, 0, 1'b0, 8'h9D, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 2, 1'b0, 8'hA5, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 0, 1'b1, 8'h5A, 1'b0};
    for (int v = 0; v < 6; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].word, vecs[v].mode, vecs[v].gaps,
                vecs[v].toggle, vecs[v].exp_word, vecs[v].exp_par);
    end

    // Abort after 4 bits, then a clean frame must not contain stale bits.
    kf.Mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      kf.ValidData = 1'b1;
      kf.InputData = ~i[0];
      tick();
    end
    check("abort_busy_pre", kf.Busy, 32'd1);
    kf.ValidData = 1'b0;
    kf.Active = 1'b0;
    tick();
    check("abort_busy_valid", {kf.Busy, kf.ValidOut}, 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (kf.ValidOut !== 1'b0 || kf.Done !== 1'b0) quiet = 1'b0;
    end
    check("abort_quiet", quiet, 32'd1);
    kf.Active = 1'b1;
    tick();
    run_frame("after_abort", 8'h81, 1'b0, 0, 1'b0, 8'h81, 1'b0);

    // Reset while the third output bit of a 0xFF frame is on the wire.
    kf.Mode = 1'b0;
    for (int i = 0; i < W; i++) begin
      kf.ValidData = 1'b1;
      kf.InputData = 1'b1;
      tick();
    end
    kf.ValidData = 1'b0;
    tick(); tick(); tick(); tick();
    check("rst_mid_third_bit", {kf.ValidOut, kf.DataOut}, 32'b11);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {kf.Busy, kf.DataOut, kf.ValidOut, kf.Done}, 32'd0);
    tick();
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (kf.ValidOut !== 1'b0 || kf.Done !== 1'b0 || kf.Busy !== 1'b0) quiet = 1'b0;
    end
    check("rst_mid_quiet", quiet, 32'd1);

    for (int r = 0; r < 40; r++) begin
      logic [W-1:0] w;
      logic         m;
      logic [W-1:0] e;
      w = W'($urandom);
      m = 1'($urandom_range(0, 1));
      e = model_word(w, m);
      run_frame($sformatf("rnd%0d", r), w, m, int'($urandom_range(0, 2)),
                bit'($urandom_range(0, 1)), e, ^e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
